tk1_exec_mon: RTL

Parametrised execution and access monitor for the tk1 SoC. It generalises the single-range CPU monitor to NUM_REGIONS independently configured address windows, each of which denies either instruction fetches or all accesses. A fixed firmware-RAM execute-deny rule is always active. Violations assert a sticky registered `force_trap`, are recorded with cause, region and address, and are counted. Configuration is done over the standard tk1 core bus and can be locked with a one-way lock.

---
 rtl/tk1_exec_mon_pkg.sv | 36 +++
 rtl/tk1_exec_mon_region.sv | 52 +++++
 rtl/tk1_exec_mon.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tk1_exec_mon_pkg.sv
// tk1_exec_mon_pkg
// Shared definitions for the tk1 execution/access monitor:
//   - core-bus word addresses of the register map
//   - violation cause codes reported in STATUS[3:2]
//   - monitor state encoding (2-bit state register)
//   - inclusive unsigned range helper used by the window comparators
package tk1_exec_mon_pkg;

    localparam logic [7:0] ADDR_CTRL        = 8'h00;
    localparam logic [7:0] ADDR_STATUS      = 8'h01;
    localparam logic [7:0] ADDR_VIOL_ADDR   = 8'h02;
    localparam logic [7:0] ADDR_VIOL_CNT    = 8'h03;
    localparam logic [7:0] ADDR_REGION_EN   = 8'h04;
    localparam logic [7:0] ADDR_REGION_MODE = 8'h05;
    // FIRST_i at ADDR_REGION_BASE + 2*i, LAST_i at ADDR_REGION_BASE + 2*i + 1
    localparam logic [7:0] ADDR_REGION_BASE = 8'h10;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_FW_EXEC  = 2'd1;
    localparam logic [1:0] CAUSE_REG_EXEC = 2'd2;
    localparam logic [1:0] CAUSE_REG_DATA = 2'd3;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_TRAPPED  = 2'd2
    } state_e;

    // Inclusive unsigned window test; an inverted window (first > last) never matches.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] first,
                                      input logic [31:0] last);
        return (addr >= first) && (addr <= last);
    endfunction

endpackage

// File: rtl/tk1_exec_mon_region.sv
// tk1_exec_mon_region
// One monitored address window: FIRST/LAST registers plus the hit comparator.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_first, wr_last     load write_data into FIRST / LAST (already gated by lock state)
//   write_data [31:0]     core-bus write data
//   en, mode              window enable; mode 0 = execute-deny, 1 = deny all accesses
//   cpu_addr, cpu_instr   current CPU access (validity is applied by the caller)
//   hit                   window matches the current access
//   first, last           register values for read-back
module tk1_exec_mon_region
    import tk1_exec_mon_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_first,
    input  logic        wr_last,
    input  logic [31:0] write_data,
    input  logic        en,
    input  logic        mode,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_instr,
    output logic        hit,
    output logic [31:0] first,
    output logic [31:0] last
);

    logic [31:0] first_q, first_d;
    logic [31:0] last_q, last_d;

    always_comb begin
        first_d = first_q;
        last_d  = last_q;
        if (wr_first) first_d = write_data;
        if (wr_last)  last_d  = write_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q <= 32'd0;
            last_q  <= 32'd0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign hit   = en && in_range(cpu_addr, first_q, last_q) && (mode || cpu_instr);
    assign first = first_q;
    assign last  = last_q;

endmodule

// File: rtl/tk1_exec_mon.sv
// tk1_exec_mon
// Execution/access monitor: NUM_REGIONS configurable windows plus a fixed
// firmware-RAM execute-deny rule. A violation latches a sticky force_trap.
// Optional macro EXEC_MON_VIOL_LOG_EN builds the violation log (VIOL_ADDR,
// VIOL_CNT, STATUS cause/region); without it those read as zero.
// Bus handshake: a transfer happens in every cycle with cs=1; ready mirrors cs
// combinationally, reads are combinational, writes commit on the next clk edge.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cpu_addr, cpu_instr, cpu_valid    observed CPU access
//   force_trap                        sticky trap request (registered)
//   cs, we, address, write_data       core bus request
//   read_data, ready                  core bus response
module tk1_exec_mon
    import tk1_exec_mon_pkg::*;
#(
    parameter int          NUM_REGIONS  = 4,
    parameter logic [31:0] FW_RAM_FIRST = 32'hd0000000,
    parameter logic [31:0] FW_RAM_LAST  = 32'hd00007ff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_instr,
    input  logic        cpu_valid,
    output logic        force_trap,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    state_e                 state_q, state_d;
    logic                   locked_q, locked_d;
    logic [NUM_REGIONS-1:0] en_q, en_d;
    logic [NUM_REGIONS-1:0] mode_q, mode_d;

    logic [NUM_REGIONS-1:0] hit_w;
    logic [31:0]            first_w [NUM_REGIONS];
    logic [31:0]            last_w  [NUM_REGIONS];

    logic bus_wr, cfg_open, ctrl_wr, fw_hit, viol, first_trap;
    logic [31:0] log_status, viol_addr_rd, viol_cnt_rd;

    assign bus_wr   = cs && we;
    assign cfg_open = (state_q == ST_UNLOCKED);
    assign ctrl_wr  = bus_wr && (address == ADDR_CTRL);

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        localparam logic [7:0] A_FIRST = ADDR_REGION_BASE + 8'(2 * i);
        localparam logic [7:0] A_LAST  = ADDR_REGION_BASE + 8'(2 * i + 1);
        tk1_exec_mon_region u_region (
            .clk        (clk),
            .reset_n    (reset_n),
            .wr_first   (cfg_open && bus_wr && (address == A_FIRST)),
            .wr_last    (cfg_open && bus_wr && (address == A_LAST)),
            .write_data (write_data),
            .en         (en_q[i]),
            .mode       (mode_q[i]),
            .cpu_addr   (cpu_addr),
            .cpu_instr  (cpu_instr),
            .hit        (hit_w[i]),
            .first      (first_w[i]),
            .last       (last_w[i])
        );
    end

    assign fw_hit     = cpu_valid && cpu_instr && in_range(cpu_addr, FW_RAM_FIRST, FW_RAM_LAST);
    assign viol       = cpu_valid && (fw_hit || (|hit_w));
    // Only the transition into TRAPPED captures the log.
    assign first_trap = viol && (state_q != ST_TRAPPED);

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        en_d     = en_q;
        mode_d   = mode_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (bus_wr && (address == ADDR_REGION_EN))   en_d   = write_data[NUM_REGIONS-1:0];
                if (bus_wr && (address == ADDR_REGION_MODE)) mode_d = write_data[NUM_REGIONS-1:0];
                if (ctrl_wr) begin
                    locked_d = 1'b1;
                    state_d  = ST_LOCKED;
                end
                // Violation wins over the lock transition; locked still records the CTRL write.
                if (viol) state_d = ST_TRAPPED;
            end
            ST_LOCKED: begin
                if (viol) state_d = ST_TRAPPED;
            end
            ST_TRAPPED: state_d = ST_TRAPPED;
            // Unused encoding falls into the safe terminal state.
            default:    state_d = ST_TRAPPED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
            en_q     <= '0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
        end
    end

    assign force_trap = (state_q == ST_TRAPPED);

`ifdef EXEC_MON_VIOL_LOG_EN
    logic [2:0]  hit_idx;
    logic [1:0]  cause_q, cause_d;
    logic [2:0]  region_q, region_d;
    logic [31:0] viol_addr_q, viol_addr_d;
    logic [15:0] viol_cnt_q, viol_cnt_d;

    // Descending scan so the lowest hitting index is the one left standing.
    always_comb begin
        hit_idx = 3'd0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_w[i]) hit_idx = 3'(i);
        end
    end

    always_comb begin
        cause_d     = cause_q;
        region_d    = region_q;
        viol_addr_d = viol_addr_q;
        viol_cnt_d  = viol_cnt_q;
        if (first_trap) begin
            viol_addr_d = cpu_addr;
            if (fw_hit) begin
                cause_d  = CAUSE_FW_EXEC;
                region_d = 3'd0;
            end else begin
                cause_d  = cpu_instr ? CAUSE_REG_EXEC : CAUSE_REG_DATA;
                region_d = hit_idx;
            end
        end
        if (viol && (viol_cnt_q != 16'hffff)) viol_cnt_d = viol_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q     <= CAUSE_NONE;
            region_q    <= 3'd0;
            viol_addr_q <= 32'd0;
            viol_cnt_q  <= 16'd0;
        end else begin
            cause_q     <= cause_d;
            region_q    <= region_d;
            viol_addr_q <= viol_addr_d;
            viol_cnt_q  <= viol_cnt_d;
        end
    end

    assign log_status   = {21'd0, region_q, 4'd0, cause_q, 2'd0};
    assign viol_addr_rd = viol_addr_q;
    assign viol_cnt_rd  = {16'd0, viol_cnt_q};
`else
    assign log_status   = 32'd0;
    assign viol_addr_rd = 32'd0;
    assign viol_cnt_rd  = 32'd0;
`endif

    assign ready = cs;

    always_comb begin
        read_data = 32'd0;
        if (cs) begin
            case (address)
                ADDR_CTRL:        read_data = {31'd0, locked_q};
                ADDR_STATUS:      read_data = log_status | {30'd0, force_trap, locked_q};
                ADDR_VIOL_ADDR:   read_data = viol_addr_rd;
                ADDR_VIOL_CNT:    read_data = viol_cnt_rd;
                ADDR_REGION_EN:   read_data = {{(32 - NUM_REGIONS){1'b0}}, en_q};
                ADDR_REGION_MODE: read_data = {{(32 - NUM_REGIONS){1'b0}}, mode_q};
                default: begin
                    for (int i = 0; i < NUM_REGIONS; i++) begin
                        if (address == ADDR_REGION_BASE + 8'(2 * i))     read_data = first_w[i];
                        if (address == ADDR_REGION_BASE + 8'(2 * i + 1)) read_data = last_w[i];
                    end
                end
            endcase
        end
    end

endmodule
